// File: rtl/delay_timer_sched.sv
// Shared delay timer: arbitrates NREQ requesters, loads one down-counter, pulses done to the winner.
// Optional `DLY_PRIO_EN: fixed lowest-index-wins arbitration instead of round-robin.
//
// state  | meaning
// IDLE   | timer free, requests sampled
// LOAD   | grant asserted, delay captured (clamped to DMAX)
// RUN    | timer counting down to zero
// DONE   | one-cycle completion pulse, pointer advances
module delay_timer_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 17,
  parameter int DMAX  = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*CBITS-1:0]   i_dly,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_done,
  output logic [CBITS-1:0]        o_cnt,
  output logic                    o_busy,
  output logic                    o_flg,
  output logic                    o_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] DMAX_C = CBITS'(DMAX);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_win;
  logic [IW-1:0]    w_win;
  logic             w_found;
  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] w_dly_sel;
  logic [CBITS-1:0] w_dly_clamp;
  logic             w_dly_over;
  logic             r_err;
  logic [NREQ-1:0]  w_win_oh;

`ifdef DLY_PRIO_EN
  // Descending scan so the lowest set index is the last to write w_win.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_win   = IW'(i);
        w_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (r_state == S_DONE) begin
      r_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
    end
  end
`endif

  always_comb begin
    w_dly_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_win == IW'(i)) w_dly_sel = i_dly[i*CBITS +: CBITS];
    end
  end

  assign w_dly_over  = (w_dly_sel > DMAX_C);
  assign w_dly_clamp = w_dly_over ? DMAX_C : w_dly_sel;
  assign w_win_oh    = NREQ'(1) << r_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_gnt       = '0;
    o_done      = '0;
    o_busy      = 1'b1;
    o_flg       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        o_flg  = 1'b1;
        if (w_found) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_gnt       = w_win_oh;
        w_state_nxt = (w_dly_clamp == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_gnt = w_win_oh;
        if (r_cnt <= CBITS'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = w_win_oh;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) r_win <= w_win;
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_LOAD: begin
          r_cnt <= w_dly_clamp;
          if (w_dly_over) r_err <= 1'b1;
        end
        S_RUN:  if (r_cnt != '0) r_cnt <= r_cnt - CBITS'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // err is visible in the LOAD cycle itself, then held by the sticky register.
  assign o_err = r_err | ((r_state == S_LOAD) && w_dly_over);
  assign o_cnt = r_cnt;

endmodule
